// File: rtl/m_calc_sched.sv
// Round-robin scheduler that time-shares one calc datapath among NREQ requesters.
// Each job: one-cycle start, wait for fin (bounded by TIMEOUT), then a flush hold-off.
module m_calc_sched #(
  parameter int NREQ    = 4,
  parameter int CGES    = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    calc_start,
  input  logic                    calc_fin,
  output logic                    calc_abort,
  output logic                    busy
);

  localparam int SW        = $clog2(NREQ);
  localparam int TW        = $clog2(TIMEOUT);
  localparam int FLUSH_LEN = ($clog2(CGES) > 0) ? $clog2(CGES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   owner;
  logic [SW-1:0]   owner_nx;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   ptr_nx;
  logic [SW-1:0]   win;
  logic [SW-1:0]   idx;
  logic            found;
  logic [TW-1:0]   tcnt;
  logic [TW-1:0]   tcnt_nx;
  logic [TW-1:0]   fcnt;
  logic [TW-1:0]   fcnt_nx;
  logic [NREQ-1:0] grant_nx;
  logic [NREQ-1:0] done_nx;
  logic [NREQ-1:0] err_nx;
  logic [SW-1:0]   sel_nx;
  logic            start_nx;
  logic            abort_nx;
  logic            busy_nx;

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting at ptr; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = SW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
  end

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    sel_nx   = sel;
    tcnt_nx  = tcnt;
    fcnt_nx  = fcnt;
    done_nx  = '0;
    err_nx   = '0;
    start_nx = 1'b0;
    abort_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nx = ST_START;
          owner_nx = win;
          sel_nx   = win;
          ptr_nx   = (win == SW'(NREQ - 1)) ? '0 : win + SW'(1);
          start_nx = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx = ST_RUN;
        tcnt_nx  = '0;
      end
      ST_RUN: begin
        // fin takes priority over a timeout landing in the same cycle
        if (calc_fin) begin
          state_nx = ST_FLUSH;
          fcnt_nx  = '0;
          done_nx  = onehot(owner);
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_nx = ST_FLUSH;
          fcnt_nx  = '0;
          err_nx   = onehot(owner);
          abort_nx = 1'b1;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      ST_FLUSH: begin
        if (fcnt == TW'(FLUSH_LEN - 1)) begin
          state_nx = ST_IDLE;
        end else begin
          fcnt_nx = fcnt + TW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    busy_nx  = (state_nx != ST_IDLE);
    grant_nx = ((state_nx == ST_START) || (state_nx == ST_RUN)) ? onehot(owner_nx) : '0;
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      ptr        <= '0;
      tcnt       <= '0;
      fcnt       <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      sel        <= '0;
      calc_start <= 1'b0;
      calc_abort <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      ptr        <= ptr_nx;
      tcnt       <= tcnt_nx;
      fcnt       <= fcnt_nx;
      grant      <= grant_nx;
      done       <= done_nx;
      err        <= err_nx;
      sel        <= sel_nx;
      calc_start <= start_nx;
      calc_abort <= abort_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_m_calc_sched.sv
// Self-checking bench for m_calc_sched: directed scenarios plus random traffic,
// all cycles compared against a job-level behavioural model.
module tb_m_calc_sched;

  localparam int NREQ    = 4;
  localparam int CGES    = 7;
  localparam int TIMEOUT = 8;
  localparam int F       = 3;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic [3:0] err;
  logic [1:0] sel;
  logic       calc_start;
  logic       calc_fin;
  logic       calc_abort;
  logic       busy;

  int n_cmp;
  int n_bad;
  int cyc;

  m_calc_sched #(.NREQ(NREQ), .CGES(CGES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .sel        (sel),
    .calc_start (calc_start),
    .calc_fin   (calc_fin),
    .calc_abort (calc_abort),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: job phase (0 idle, 1 start, 2 run, 3 flush), owner, fairness pointer.
  int         m_phase;
  int         m_owner;
  int         m_ptr;
  int         m_runs;
  int         m_flush;
  logic [3:0] e_grant;
  logic [3:0] e_done;
  logic [3:0] e_err;
  logic [1:0] e_sel;
  logic       e_start;
  logic       e_abort;
  logic       e_busy;

  wire [16:0] obs = {grant, done, err, sel, calc_start, calc_abort, busy};

  function automatic logic [16:0] expv();
    return {e_grant, e_done, e_err, e_sel, e_start, e_abort, e_busy};
  endfunction

  task automatic model_update(input logic [3:0] r, input logic f, input logic rn);
    bit got;
    int c;
    e_grant = 4'b0000;
    e_done  = 4'b0000;
    e_err   = 4'b0000;
    e_start = 1'b0;
    e_abort = 1'b0;
    if (!rn) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_runs = 0; m_flush = 0;
      e_sel = 2'd0; e_busy = 1'b0;
      return;
    end
    case (m_phase)
      0: begin
        got = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          c = (m_ptr + i) % NREQ;
          if (!got && r[c]) begin
            got = 1'b1;
            m_owner = c;
          end
        end
        if (got) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_phase = 1;
          e_start = 1'b1;
          e_sel   = 2'(m_owner);
          e_grant = 4'b0001 << m_owner;
        end
      end
      1: begin
        m_phase = 2;
        m_runs  = 0;
        e_grant = 4'b0001 << m_owner;
      end
      2: begin
        m_runs = m_runs + 1;
        if (f) begin
          e_done = 4'b0001 << m_owner; m_phase = 3; m_flush = F;
        end else if (m_runs == TIMEOUT) begin
          e_err = 4'b0001 << m_owner; e_abort = 1'b1; m_phase = 3; m_flush = F;
        end else begin
          e_grant = 4'b0001 << m_owner;
        end
      end
      default: begin
        m_flush = m_flush - 1;
        if (m_flush == 0) m_phase = 0;
      end
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic step(input logic [3:0] r, input logic f, input logic rn);
    req      = r;
    calc_fin = f;
    reset_n  = rn;
    model_update(r, f, rn);
    @(posedge clk);
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  task automatic test_reset();
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== 17'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 17'd0);
    end
    n_cmp++;
    if (obs !== expv()) begin
      n_bad++; $display("FAIL reset_model got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_single();
    int done_cnt;
    done_cnt = 0;
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step((k < 6) ? 4'b0100 : 4'b0000, (k == 5), 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL single k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (done != 4'b0000) done_cnt++;
      if (k == 0) begin
        n_cmp++;
        if ({grant, sel, calc_start} !== {4'b0100, 2'd2, 1'b1}) begin
          n_bad++; $display("FAIL single_grant got=%b/%0d/%b exp=0100/2/1", grant, sel, calc_start);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (done !== 4'b0100) begin
          n_bad++; $display("FAIL single_done got=%b exp=0100", done);
        end
      end
      if (k == 7 || k == 8) begin
        n_cmp++;
        if (busy !== (k == 7)) begin
          n_bad++; $display("FAIL single_busy cycle=%0d got=%b exp=%b", k + 1, busy, (k == 7));
        end
      end
      if (k > 8) begin
        n_cmp++;
        if (grant !== 4'b0000) begin
          n_bad++; $display("FAIL single_nogrant got=%b exp=0000", grant);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL single_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [3:0] rq;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    step(4'b0000, 1'b0, 1'b0);
    rq = 4'b1111;
    for (int k = 0; k < 45; k++) begin
      step(rq, (m_phase == 2 && m_runs == 1), 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL rr k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (calc_start) order.push_back(int'(sel));
      rq = 4'b1111 & ~done;
    end
    n_cmp++;
    if (order.size() < 5) begin
      n_bad++; $display("FAIL rr_count got=%0d exp>=5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (order[i] != exp_order[i]) begin
          n_bad++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int err_cnt;
    int abort_cnt;
    int done_cnt;
    int err_cyc;
    logic [3:0] rq;
    err_cnt = 0; abort_cnt = 0; done_cnt = 0; err_cyc = -1;
    step(4'b0000, 1'b0, 1'b0);
    rq = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      step(rq, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL timeout k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (err != 4'b0000) begin
        err_cnt++; err_cyc = k + 1; rq = 4'b0000;
        n_cmp++;
        if (err !== 4'b0001) begin
          n_bad++; $display("FAIL timeout_err_bits got=%b exp=0001", err);
        end
      end
      if (calc_abort) abort_cnt++;
      if (done != 4'b0000) done_cnt++;
      if (k == 12) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++; $display("FAIL timeout_idle got=%b exp=0", busy);
        end
      end
    end
    n_cmp++;
    if ({err_cnt, abort_cnt, done_cnt, err_cyc} != {32'd1, 32'd1, 32'd0, 32'd10}) begin
      n_bad++;
      $display("FAIL timeout_counts err=%0d abort=%0d done=%0d at=%0d exp 1 1 0 10",
               err_cnt, abort_cnt, done_cnt, err_cyc);
    end
  endtask

  task automatic test_fin_timeout();
    int err_cnt;
    int abort_cnt;
    int done_cnt;
    logic [3:0] rq;
    err_cnt = 0; abort_cnt = 0; done_cnt = 0;
    step(4'b0000, 1'b0, 1'b0);
    rq = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      step(rq, (m_phase == 2 && m_runs == TIMEOUT - 1), 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL fin_timeout k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (err != 4'b0000) err_cnt++;
      if (calc_abort) abort_cnt++;
      if (done != 4'b0000) begin
        done_cnt++; rq = 4'b0000;
      end
    end
    n_cmp++;
    if ({err_cnt, abort_cnt, done_cnt} != {32'd0, 32'd0, 32'd1}) begin
      n_bad++;
      $display("FAIL fin_timeout_counts err=%0d abort=%0d done=%0d exp 0 0 1", err_cnt, abort_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulse_cnt;
    pulse_cnt = 0;
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== 17'd0) begin
      n_bad++; $display("FAIL midreset_outputs got=%h exp=0", obs);
    end
    step(4'b1010, 1'b0, 1'b1);
    n_cmp++;
    if ({grant, sel} !== {4'b0010, 2'd1}) begin
      n_bad++; $display("FAIL midreset_first got=%b/%0d exp=0010/1", grant, sel);
    end
    for (int k = 0; k < 6; k++) begin
      step(4'b1010, (k == 2), 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL midreset k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (err != 4'b0000) pulse_cnt++;
    end
    n_cmp++;
    if (pulse_cnt != 0) begin
      n_bad++; $display("FAIL midreset_err got=%0d exp=0", pulse_cnt);
    end
  endtask

  task automatic test_spurious();
    logic [3:0] rq_tab[12] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       fn_tab[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int done_cnt;
    done_cnt = 0;
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(rq_tab[k], fn_tab[k], 1'b1);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL spurious k=%0d got=%h exp=%h", k, obs, expv());
      end
      if (done != 4'b0000) done_cnt++;
      if (k < 3) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++; $display("FAIL spurious_idle k=%0d got=%b exp=0", k, busy);
        end
      end
      if (k == 7) begin
        n_cmp++;
        if (done !== 4'b0001) begin
          n_bad++; $display("FAIL spurious_done got=%b exp=0001", done);
        end
      end
      if (k == 10) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_bad++; $display("FAIL spurious_flush_end got=%b exp=0", busy);
        end
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++; $display("FAIL spurious_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] rq;
    logic       fn;
    logic       rn;
    step(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 800; k++) begin
      rq = 4'($urandom);
      fn = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step(rq, fn, rn);
      n_cmp++;
      if (obs !== expv()) begin
        n_bad++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, expv());
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    req      = 4'b0000;
    calc_fin = 1'b0;
    m_phase = 0; m_owner = 0; m_ptr = 0; m_runs = 0; m_flush = 0;
    e_grant = 4'b0000; e_done = 4'b0000; e_err = 4'b0000;
    e_sel = 2'd0; e_start = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_fin_timeout();
    test_reset_mid_run();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
